lsu: RTL and testbench

Load/store unit that sits directly downstream of the multi-cycle CPU's MEM_ACCESS state and upstream of the data memory. It accepts one load or store request at a time and drives the byte-lane memory interface: mem_addr, mem_wdata, mem_wmask, mem_rmask, mem_rdata, mem_rbusy, mem_wbusy. It returns sign- or zero-extended load data, or store completion, together with an error flag. No queueing; one transaction is in flight at most.

---
 rtl/lsu.sv | 164 ++++++++++++++++
 tb/tb_lsu.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit between the multi-cycle CPU's memory stage and a byte-lane data memory.
// One transaction in flight; aligned accesses only; optional busy timeout.
module lsu #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    output logic [3:0]  mem_rmask,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rbusy,
    input  logic        mem_wbusy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [2:0]       funct3_q;
    logic [1:0]       addr_lo_q;
    logic [CNT_W-1:0] cnt;

    logic [3:0]  acc_mask;
    logic [31:0] acc_wdata;
    logic        acc_err;
    logic [31:0] shifted;
    logic [15:0] half;
    logic [31:0] load_ext;
    logic        timeout_hit;

    // Lane pattern, replicated store data and legality of the incoming request.
    always_comb begin
        acc_mask  = '0;
        acc_wdata = req_wdata;
        acc_err   = 1'b0;
        case (req_funct3[1:0])
            2'b00: begin
                acc_mask  = 4'b0001 << req_addr[1:0];
                acc_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                acc_mask  = req_addr[1] ? 4'b1100 : 4'b0011;
                acc_wdata = {2{req_wdata[15:0]}};
                acc_err   = req_addr[0];
            end
            2'b10: begin
                acc_mask = 4'b1111;
                acc_err  = |req_addr[1:0];
            end
            default: acc_err = 1'b1;
        endcase
        if (req_we && req_funct3[2])
            acc_err = 1'b1;
        if (!req_we && req_funct3[2] && req_funct3[1])
            acc_err = 1'b1;
    end

    always_comb begin
        shifted  = mem_rdata >> {addr_lo_q, 3'b000};
        half     = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_ext = mem_rdata;
        case (funct3_q)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{16{half[15]}}, half};
            3'b100:  load_ext = {24'b0, shifted[7:0]};
            3'b101:  load_ext = {16'b0, half};
            default: load_ext = mem_rdata;
        endcase
    end

    // Fires on the busy edge that brings the consecutive-busy count up to TIMEOUT.
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            funct3_q   <= '0;
            addr_lo_q  <= '0;
            cnt        <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
            mem_rmask  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        funct3_q  <= req_funct3;
                        addr_lo_q <= req_addr[1:0];
                        mem_addr  <= {req_addr[31:2], 2'b00};
                        mem_wdata <= acc_wdata;
                        cnt       <= '0;
                        if (acc_err) begin
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            state      <= S_RESP;
                        end else if (req_we) begin
                            mem_wmask <= acc_mask;
                            state     <= S_WR;
                        end else begin
                            mem_rmask <= acc_mask;
                            state     <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    if (!mem_rbusy) begin
                        resp_rdata <= load_ext;
                        resp_err   <= 1'b0;
                        mem_rmask  <= '0;
                        state      <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (timeout_hit) begin
                            resp_rdata <= '0;
                            resp_err   <= 1'b1;
                            mem_rmask  <= '0;
                            state      <= S_RESP;
                        end
                    end
                end
                S_WR: begin
                    if (!mem_wbusy) begin
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                        mem_wmask  <= '0;
                        state      <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (timeout_hit) begin
                            resp_rdata <= '0;
                            resp_err   <= 1'b1;
                            mem_wmask  <= '0;
                            state      <= S_RESP;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: lane/extension vectors, alignment errors, busy stretch,
// timeout and mid-transaction reset, all against hand-computed values.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [3:0]  mem_rmask;
    logic [31:0] mem_rdata;
    logic        mem_rbusy;
    logic        mem_wbusy;

    int n_cmp = 0;
    int n_bad = 0;

    lsu #(.TIMEOUT(16), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_rmask  (mem_rmask),
        .mem_rdata  (mem_rdata),
        .mem_rbusy  (mem_rbusy),
        .mem_wbusy  (mem_wbusy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present a request for one edge; returns 1 time unit after the accept edge.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk); #1;
        req_valid  = 1'b0;
    endtask

    // Bounded wait for resp_valid; checks latency, data, error, then the return to IDLE.
    task automatic expect_resp(input string tag, input int exp_lat, input logic [31:0] exp_rdata,
                               input logic exp_err);
        int lat = 1;
        while (!resp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        check({tag, ".valid"}, 32'(resp_valid), 32'd1);
        check({tag, ".rdata"}, resp_rdata, exp_rdata);
        check({tag, ".err"}, 32'(resp_err), 32'(exp_err));
        check({tag, ".masks"}, {24'b0, mem_wmask, mem_rmask}, 32'h0);
        @(posedge clk); #1;
        check({tag, ".pulse"}, 32'(resp_valid), 32'd0);
        check({tag, ".ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        mem_rdata = '0; mem_rbusy = 1'b0; mem_wbusy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.ready", 32'(req_ready), 32'd1);
        check("rst.valid", 32'(resp_valid), 32'd0);
        check("rst.masks", {24'b0, mem_wmask, mem_rmask}, 32'h0);
        check("rst.addr", mem_addr, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // SW word store
        issue(1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF);
        check("sw.addr", mem_addr, 32'h0000_0104);
        check("sw.wmask", 32'(mem_wmask), 32'hF);
        check("sw.wdata", mem_wdata, 32'hDEAD_BEEF);
        check("sw.rmask", 32'(mem_rmask), 32'h0);
        expect_resp("sw", 2, 32'h0, 1'b0);

        // LB / LBU from the top byte lane
        mem_rdata = 32'h80FF_1234;
        issue(1'b0, 3'b000, 32'h0000_0103, 32'h0);
        check("lb.rmask", 32'(mem_rmask), 32'h8);
        check("lb.addr", mem_addr, 32'h0000_0100);
        expect_resp("lb", 2, 32'hFFFF_FF80, 1'b0);
        issue(1'b0, 3'b100, 32'h0000_0103, 32'h0);
        expect_resp("lbu", 2, 32'h0000_0080, 1'b0);

        // SH upper half, LHU upper half, LH lower half sign-extended
        issue(1'b1, 3'b001, 32'h0000_0022, 32'h0000_ABCD);
        check("sh.addr", mem_addr, 32'h0000_0020);
        check("sh.wmask", 32'(mem_wmask), 32'hC);
        check("sh.wdata", mem_wdata, 32'hABCD_ABCD);
        expect_resp("sh", 2, 32'h0, 1'b0);
        mem_rdata = 32'hABCD_0000;
        issue(1'b0, 3'b101, 32'h0000_0022, 32'h0);
        check("lhu.rmask", 32'(mem_rmask), 32'hC);
        expect_resp("lhu", 2, 32'h0000_ABCD, 1'b0);
        mem_rdata = 32'h1234_8001;
        issue(1'b0, 3'b001, 32'h0000_0020, 32'h0);
        check("lh.rmask", 32'(mem_rmask), 32'h3);
        expect_resp("lh", 2, 32'hFFFF_8001, 1'b0);

        // SB into lane 1
        issue(1'b1, 3'b000, 32'h0000_0101, 32'h1234_565A);
        check("sb.wmask", 32'(mem_wmask), 32'h2);
        check("sb.wdata", mem_wdata, 32'h5A5A_5A5A);
        expect_resp("sb", 2, 32'h0, 1'b0);

        // Misaligned and illegal requests (previous rdata nonzero makes rdata=0 meaningful)
        mem_rdata = 32'hCAFE_F00D;
        issue(1'b0, 3'b010, 32'h0000_0040, 32'h0);
        expect_resp("lw_ok", 2, 32'hCAFE_F00D, 1'b0);
        issue(1'b0, 3'b001, 32'h0000_0021, 32'h0);
        expect_resp("lh_mis", 1, 32'h0, 1'b1);
        issue(1'b0, 3'b010, 32'h0000_0102, 32'h0);
        expect_resp("lw_mis", 1, 32'h0, 1'b1);
        issue(1'b0, 3'b011, 32'h0000_0000, 32'h0);
        expect_resp("ld_f3", 1, 32'h0, 1'b1);
        issue(1'b1, 3'b100, 32'h0000_0000, 32'h0);
        expect_resp("st_f3", 1, 32'h0, 1'b1);

        // LW with five busy cycles
        mem_rbusy = 1'b1;
        mem_rdata = 32'h0;
        issue(1'b0, 3'b010, 32'h0000_0040, 32'h0);
        repeat (5) @(posedge clk);
        #1;
        check("lwb.held", 32'(resp_valid), 32'd0);
        check("lwb.rmask", 32'(mem_rmask), 32'hF);
        mem_rbusy = 1'b0;
        mem_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        expect_resp("lwb", 1, 32'h1234_5678, 1'b0);

        // Stuck busy: aborts on the 16th busy edge, response one cycle later
        mem_rbusy = 1'b1;
        issue(1'b0, 3'b010, 32'h0000_0040, 32'h0);
        expect_resp("lwto", 17, 32'h0, 1'b1);
        mem_rbusy = 1'b0;

        // Reset in the middle of a stalled store
        mem_wbusy = 1'b1;
        issue(1'b1, 3'b010, 32'h0000_0080, 32'h1122_3344);
        check("rstwr.wmask", 32'(mem_wmask), 32'hF);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rstwr.drop", 32'(mem_wmask), 32'h0);
        check("rstwr.valid", 32'(resp_valid), 32'd0);
        check("rstwr.ready", 32'(req_ready), 32'd1);
        @(posedge clk); #2;
        rst = 1'b0;
        mem_wbusy = 1'b0;
        @(posedge clk); #1;
        check("rstwr.novalid", 32'(resp_valid), 32'd0);
        issue(1'b1, 3'b010, 32'h0000_0008, 32'h0BAD_F00D);
        check("rstwr.wdata", mem_wdata, 32'h0BAD_F00D);
        expect_resp("rstwr.sw", 2, 32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
